uart_reg_ctrl: RTL and testbench

//  Command sequencer between the UART receiver/transmitter and the register

---
 rtl/uart_reg_ctrl.sv | 116 +++++++++++
 tb/tb_uart_reg_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_ctrl.sv
// uart_reg_ctrl: turns the UART byte stream into register-bus commands.
//   1xxxxxxx dd : write dd to register xxxxxxx
//   0xxxxxxx    : read register xxxxxxx, value returned over UART TX
//   00000000    : NOP / resync
// All outputs are registered; strobes are single-cycle.
module uart_reg_ctrl #(
   parameter int CLK_HZ       = 50000000,
   parameter int BIT_RATE     = 9600,
   parameter int TIMEOUT_BITS = 30
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       uart_rx_valid,
   input  logic [7:0] uart_rx_data,
   input  logic       uart_tx_busy,
   output logic       uart_tx_en,
   output logic [7:0] uart_tx_data,
   output logic [6:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wen,
   output logic       reg_ren,
   input  logic [7:0] reg_rdata,
   output logic       err_timeout,
   output logic       err_overrun
);

   localparam int TO_CYC = CLK_HZ / BIT_RATE * TIMEOUT_BITS;
   localparam int TW     = $clog2(TO_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

   typedef enum logic [2:0] {
      IDLE, WDATA, WRITE, READ, CAPT, TXW, TXH
   } state_t;

   state_t        state, state_nx;
   logic [TW-1:0] timer;

   logic is_nop, is_wr, timed_out;
   logic wen_d, ren_d, tx_en_d, to_d, ov_d;

   assign is_nop    = (uart_rx_data == 8'h00);
   assign is_wr     = uart_rx_data[7];
   assign timed_out = (state == WDATA) && !uart_rx_valid && (timer == TO_LAST);

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // Next-state decode
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (uart_rx_valid && !is_nop) state_nx = is_wr ? WDATA : READ;
         WDATA: if (uart_rx_valid)            state_nx = WRITE;
                else if (timed_out)           state_nx = IDLE;
         WRITE: state_nx = IDLE;
         READ:  state_nx = CAPT;
         CAPT:  state_nx = TXW;
         TXW:   if (!uart_tx_busy)            state_nx = TXH;
         TXH:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output decode: strobes line up with the state they belong to
   always_comb begin
      wen_d   = (state_nx == WRITE);
      ren_d   = (state_nx == READ);
      tx_en_d = (state == TXW) && (state_nx == TXH);
      to_d    = timed_out;
      ov_d    = uart_rx_valid && (state inside {WRITE, READ, CAPT, TXW, TXH});
   end

   // Registered strobes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         reg_wen     <= 1'b0;
         reg_ren     <= 1'b0;
         uart_tx_en  <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         reg_wen     <= wen_d;
         reg_ren     <= ren_d;
         uart_tx_en  <= tx_en_d;
         err_timeout <= to_d;
         err_overrun <= ov_d;
      end
   end

   // Address/data latches and write-data timer; latches hold between commands
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         reg_addr     <= '0;
         reg_wdata    <= '0;
         uart_tx_data <= '0;
         timer        <= '0;
      end else begin
         case (state)
            IDLE: if (uart_rx_valid && !is_nop) begin
               reg_addr <= uart_rx_data[6:0];
               timer    <= '0;
            end
            WDATA: begin
               if (uart_rx_valid)   reg_wdata <= uart_rx_data;
               else if (!timed_out) timer     <= timer + 1'b1;
            end
            CAPT: uart_tx_data <= reg_rdata;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Bench for uart_reg_ctrl: directed scenarios plus random command mix,
// checked against a register-file model and observed bus/UART events.
module tb_uart_reg_ctrl;

   localparam int CLK_HZ       = 38400;
   localparam int BIT_RATE     = 9600;
   localparam int TIMEOUT_BITS = 5;
   localparam int TO_CYC       = CLK_HZ / BIT_RATE * TIMEOUT_BITS;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       uart_rx_valid = 1'b0;
   logic [7:0] uart_rx_data = 8'h00;
   logic       uart_tx_busy;
   logic       uart_tx_en;
   logic [7:0] uart_tx_data;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wen, reg_ren;
   logic [7:0] reg_rdata = 8'h00;
   logic       err_timeout, err_overrun;

   uart_reg_ctrl #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
      .clk(clk), .resetn(resetn),
      .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
      .uart_tx_busy(uart_tx_busy), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wen(reg_wen), .reg_ren(reg_ren),
      .reg_rdata(reg_rdata), .err_timeout(err_timeout), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register bank on the bus; contents start from a fixed pattern
   logic [7:0] bank [128];
   logic       bank_init = 1'b0;
   always @(posedge clk) begin
      if (!bank_init) begin
         for (int i = 0; i < 128; i++) bank[i] <= 8'(i * 37 + 5);
         bank_init <= 1'b1;
      end else begin
         if (reg_wen) bank[reg_addr] <= reg_wdata;
         if (reg_ren) reg_rdata <= bank[reg_addr];
      end
   end

   // Transmitter: busy for a few cycles starting the cycle after tx_en
   logic busy_force = 1'b0;
   int   busy_cnt = 0;
   always @(posedge clk) begin
      if (uart_tx_en)        busy_cnt <= 6;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign uart_tx_busy = busy_force | (busy_cnt != 0);

   // Event monitor
   logic [6:0] wa_q[$], ra_q[$];
   logic [7:0] wd_q[$], td_q[$];
   int         wc_q[$], rc_q[$], toc_q[$], ovc_q[$];
   logic       busy_at_edge = 1'b0;
   int         tx_busy_viol = 0;
   always @(posedge clk) busy_at_edge <= uart_tx_busy;
   always @(negedge clk) begin
      if (reg_wen) begin wa_q.push_back(reg_addr); wd_q.push_back(reg_wdata); wc_q.push_back(cyc); end
      if (reg_ren) begin ra_q.push_back(reg_addr); rc_q.push_back(cyc); end
      if (uart_tx_en) begin
         td_q.push_back(uart_tx_data);
         if (busy_at_edge) tx_busy_viol++;
      end
      if (err_timeout) toc_q.push_back(cyc);
      if (err_overrun) ovc_q.push_back(cyc);
   end

   int n_assert = 0, n_fail = 0;
   int wi = 0, ri = 0, ti = 0, toi = 0, ovi = 0;
   logic [7:0] exp_mem [128];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, output int c);
      uart_rx_valid = 1'b1;
      uart_rx_data  = b;
      c = cyc;
      @(negedge clk);
      uart_rx_valid = 1'b0;
      uart_rx_data  = 8'($urandom);
   endtask

   task automatic check_no_extra(input string tag);
      check({tag, "_wen_extra"}, 32'(wa_q.size() - wi), 0);
      check({tag, "_ren_extra"}, 32'(ra_q.size() - ri), 0);
      check({tag, "_tx_extra"},  32'(td_q.size() - ti), 0);
      check({tag, "_to_extra"},  32'(toc_q.size() - toi), 0);
      check({tag, "_ov_extra"},  32'(ovc_q.size() - ovi), 0);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d, input int gap);
      int c0, c1;
      send_byte({1'b1, a}, c0);
      idle(gap);
      send_byte(d, c1);
      idle(2);
      exp_mem[a] = d;
      check("wr_count", 32'(wa_q.size() - wi), 1);
      if (wa_q.size() > wi) begin
         check("wr_addr", 32'(wa_q[wi]), 32'(a));
         check("wr_data", 32'(wd_q[wi]), 32'(d));
         check("wr_lat",  32'(wc_q[wi]), 32'(c1 + 1));
         wi++;
      end
   endtask

   task automatic do_read(input logic [6:0] a, input int busy_hold);
      int c0;
      busy_force = (busy_hold > 0);
      send_byte({1'b0, a}, c0);
      if (busy_hold > 0) begin
         idle(busy_hold);
         check("rd_tx_while_busy", 32'(td_q.size() - ti), 0);
         busy_force = 1'b0;
      end
      for (int k = 0; k < 60 && td_q.size() == ti; k++) @(negedge clk);
      check("rd_tx_seen", 32'(td_q.size() > ti), 1);
      check("rd_ren_count", 32'(ra_q.size() - ri), 1);
      if (ra_q.size() > ri) begin
         check("rd_addr", 32'(ra_q[ri]), 32'(a));
         check("rd_lat",  32'(rc_q[ri]), 32'(c0 + 1));
         ri++;
      end
      if (td_q.size() > ti) begin
         check("rd_txdata", 32'(td_q[ti]), 32'(exp_mem[a]));
         ti++;
      end
      idle(2);
   endtask

   initial begin
      int c0, c2;
      for (int i = 0; i < 128; i++) exp_mem[i] = 8'(i * 37 + 5);

      // Reset state
      idle(3);
      check("reset_outputs", 32'({uart_tx_en, uart_tx_data, reg_addr, reg_wdata,
                                  reg_wen, reg_ren, err_timeout, err_overrun}), 0);
      resetn = 1'b1;
      idle(2);

      // 1: basic write
      do_write(7'h41, 8'h31, 0);
      check_no_extra("t1");

      // 2: read back with busy held for a while
      do_read(7'h41, 6);
      check_no_extra("t2");

      // 3: NOPs, then write of 00 to 7'h01
      repeat (3) send_byte(8'h00, c0);
      idle(3);
      check_no_extra("t3_nop");
      do_write(7'h01, 8'h00, 1);
      check_no_extra("t3");

      // 4: write timeout, then a read is decoded as a command
      send_byte(8'h82, c0);
      idle(TO_CYC + 4);
      check("to_count", 32'(toc_q.size() - toi), 1);
      if (toc_q.size() > toi) begin
         check("to_cycle", 32'(toc_q[toi]), 32'(c0 + 1 + TO_CYC));
         toi++;
      end
      do_read(7'h42, 0);
      check_no_extra("t4");

      // 4b: data arriving on the timeout cycle wins
      do_write(7'h05, 8'h5A, TO_CYC - 1);
      check_no_extra("t4b");

      // 5: overrun during a read blocked by busy
      busy_force = 1'b1;
      send_byte(8'h43, c0);
      idle(1);
      send_byte(8'h44, c2);
      idle(5);
      check("ov_tx_held", 32'(td_q.size() - ti), 0);
      busy_force = 1'b0;
      for (int k = 0; k < 60 && td_q.size() == ti; k++) @(negedge clk);
      idle(2);
      check("ov_count", 32'(ovc_q.size() - ovi), 1);
      if (ovc_q.size() > ovi) begin
         check("ov_cycle", 32'(ovc_q[ovi]), 32'(c2 + 1));
         ovi++;
      end
      check("ov_ren_count", 32'(ra_q.size() - ri), 1);
      if (ra_q.size() > ri) begin check("ov_ren_addr", 32'(ra_q[ri]), 32'h43); ri++; end
      check("ov_tx_count", 32'(td_q.size() - ti), 1);
      if (td_q.size() > ti) begin check("ov_txdata", 32'(td_q[ti]), 32'(exp_mem[7'h43])); ti++; end
      check_no_extra("t5");

      // 6: reset in the middle of a write command
      send_byte(8'hC4, c0);
      idle(2);
      resetn = 1'b0;
      #1;
      check("midreset_outputs", 32'({uart_tx_en, uart_tx_data, reg_addr, reg_wdata,
                                     reg_wen, reg_ren, err_timeout, err_overrun}), 0);
      @(negedge clk);
      resetn = 1'b1;
      idle(1);
      do_read(7'h31, 0);
      check_no_extra("t6");

      // Random command mix against the register model
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0: begin send_byte(8'h00, c0); idle($urandom_range(0, 2)); end
            1: do_write(7'($urandom), 8'($urandom), $urandom_range(0, 4));
            default: do_read(7'($urandom_range(1, 127)), ($urandom_range(0, 3) == 0) ? 3 : 0);
         endcase
         check_no_extra("rand");
      end

      check("tx_during_busy", 32'(tx_busy_viol), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
